snake_tick_gen: RTL and testbench

Programmable game-tick generator for the snake core. Replaces the free-running power-of-two divisor with a parametrised divisor whose period is selected by a speed level, so the game accelerates as the score rises. Emits a one-cycle `tick` strobe that the movement and timer logic consume, and keeps a saturating count of elapsed ticks. Has run/pause/idle control so pausing the game freezes time without losing the partial period.

---
 rtl/snake_pkg.sv | 15 +
 rtl/tick_period_calc.sv | 39 +++
 rtl/snake_tick_gen.sv | 119 +++++++++++
 tb/tb_snake_tick_gen.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared types and 25 MHz timing defaults for the snake core.
// Imported by tick_period_calc and snake_tick_gen.
package snake_pkg;

    localparam int DEF_BASE_DIV = 25_000_000;
    localparam int DEF_STEP_DIV = 2_500_000;
    localparam int DEF_MIN_DIV  = 2_500_000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } tick_state_t;

endpackage

// File: rtl/tick_period_calc.sv
// Combinational speed-level to tick-period mapping:
// P = max(BASE_DIV - lvl*STEP_DIV, MIN_DIV), with lvl clamped to LEVELS-1.
module tick_period_calc
    import snake_pkg::*;
#(
    parameter int CNT_W    = 26,
    parameter int LEVELS   = 8,
    parameter int BASE_DIV = DEF_BASE_DIV,
    parameter int STEP_DIV = DEF_STEP_DIV,
    parameter int MIN_DIV  = DEF_MIN_DIV
) (
    input  logic [$clog2(LEVELS)-1:0] level,
    output logic [CNT_W-1:0]          period
);

    localparam int LVL_W  = $clog2(LEVELS);
    localparam int CALC_W = CNT_W + LVL_W + 1;
    localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(LEVELS - 1);

    logic [LVL_W-1:0]         lvl;
    logic signed [CALC_W-1:0] prod;
    logic signed [CALC_W-1:0] diff;

    // The clamp only exists when the level field can encode values past LEVELS-1.
    if ((1 << LVL_W) > LEVELS) begin : g_clamp
        assign lvl = (level > LVL_MAX) ? LVL_MAX : level;
    end else begin : g_no_clamp
        assign lvl = level;
    end

    // Signed arithmetic one bit wider than the product, so a large level
    // goes negative and hits the floor instead of wrapping to a huge period.
    always_comb begin
        prod   = $signed({{(CALC_W-LVL_W){1'b0}}, lvl}) * $signed(CALC_W'(STEP_DIV));
        diff   = $signed(CALC_W'(BASE_DIV)) - prod;
        period = (diff < $signed(CALC_W'(MIN_DIV))) ? CNT_W'(MIN_DIV) : CNT_W'(diff);
    end

endmodule

// File: rtl/snake_tick_gen.sv
// Programmable game-tick generator: IDLE/RUN/PAUSE FSM, period counter, elapsed ticks.
// Optional square-wave output tick_sq when SNAKE_TICK_SQUARE_EN is defined.
module snake_tick_gen
    import snake_pkg::*;
#(
    parameter int CNT_W     = 26,
    parameter int LEVELS    = 8,
    parameter int BASE_DIV  = DEF_BASE_DIV,
    parameter int STEP_DIV  = DEF_STEP_DIV,
    parameter int MIN_DIV   = DEF_MIN_DIV,
    parameter int ELAPSED_W = 16
) (
    input  logic                      clock_25,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      pause,
    input  logic                      clear,
    input  logic [$clog2(LEVELS)-1:0] level,
    output logic                      tick,
    output logic                      running,
    output logic [ELAPSED_W-1:0]      elapsed
`ifdef SNAKE_TICK_SQUARE_EN
    ,
    output logic                      tick_sq
`endif
);

    tick_state_t          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CNT_W-1:0]     period_q, period_d;
    logic [CNT_W-1:0]     p_calc;
    logic [ELAPSED_W-1:0] elapsed_d;
    logic                 tick_d;

    tick_period_calc #(
        .CNT_W    (CNT_W),
        .LEVELS   (LEVELS),
        .BASE_DIV (BASE_DIV),
        .STEP_DIV (STEP_DIV),
        .MIN_DIV  (MIN_DIV)
    ) u_period (
        .level  (level),
        .period (p_calc)
    );

    // NOTE: every variable gets a default before the case so no path infers a latch.
    always_comb begin
        state_d = state_q;
        if (!start) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = RUN;
                RUN:     if (pause)  state_d = PAUSE;
                PAUSE:   if (!pause) state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_d     = cnt_q;
        period_d  = period_q;
        elapsed_d = elapsed;
        tick_d    = 1'b0;
        if (!start || state_q == IDLE) begin
            cnt_d = '0;
            if (state_q == IDLE && start) period_d = p_calc;
        end else if (state_q == RUN) begin
            // A wrap still completes when pause arrives in the same cycle.
            if (cnt_q == period_q - 1'b1) begin
                cnt_d     = '0;
                tick_d    = 1'b1;
                period_d  = p_calc;
                elapsed_d = (&elapsed) ? elapsed : elapsed + 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        if (clear) begin
            cnt_d     = '0;
            elapsed_d = '0;
            tick_d    = 1'b0;
            period_d  = p_calc;
        end
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            period_q <= CNT_W'(BASE_DIV);
            elapsed  <= '0;
            tick     <= 1'b0;
            running  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            elapsed  <= elapsed_d;
            tick     <= tick_d;
            running  <= (state_d == RUN);
        end
    end

`ifdef SNAKE_TICK_SQUARE_EN
    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            tick_sq <= 1'b0;
        end else if (!start) begin
            tick_sq <= 1'b0;
        end else if (tick_d) begin
            tick_sq <= ~tick_sq;
        end
    end
`endif

endmodule

// File: tb/tb_snake_tick_gen.sv
// Directed self-checking bench for snake_tick_gen (BASE_DIV=10, STEP_DIV=2, MIN_DIV=4).
// Also exercises tick_period_calc clamping with LEVELS=3 and LEVELS=8 instances.
module tb_snake_tick_gen;

    logic       clock_25;
    logic       reset;
    logic       start;
    logic       pause;
    logic       clear;
    logic [1:0] level;
    logic       tick;
    logic       running;
    logic [3:0] elapsed;
    logic [1:0] lvl3;
    logic [2:0] lvl8;
    logic [3:0] p3;
    logic [3:0] p8;
`ifdef SNAKE_TICK_SQUARE_EN
    logic       tick_sq;
    logic       exp_sq;
`endif

    int total = 0;
    int bad   = 0;
    int n;

    snake_tick_gen #(
        .CNT_W     (4),
        .LEVELS    (4),
        .BASE_DIV  (10),
        .STEP_DIV  (2),
        .MIN_DIV   (4),
        .ELAPSED_W (4)
    ) dut (
        .clock_25 (clock_25),
        .reset    (reset),
        .start    (start),
        .pause    (pause),
        .clear    (clear),
        .level    (level),
        .tick     (tick),
        .running  (running),
        .elapsed  (elapsed)
`ifdef SNAKE_TICK_SQUARE_EN
        ,
        .tick_sq  (tick_sq)
`endif
    );

    tick_period_calc #(.CNT_W(4), .LEVELS(3), .BASE_DIV(10), .STEP_DIV(2), .MIN_DIV(4))
        u_calc3 (.level(lvl3), .period(p3));

    tick_period_calc #(.CNT_W(4), .LEVELS(8), .BASE_DIV(10), .STEP_DIV(2), .MIN_DIV(4))
        u_calc8 (.level(lvl8), .period(p8));

    initial clock_25 = 1'b0;
    always #5 clock_25 = ~clock_25;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock_25);
        #1;
    endtask

    // Steps until tick is seen or the budget runs out; returns cycles taken.
    task automatic count_to_tick(input int limit, output int cycles);
        cycles = 0;
        do begin
            step();
            cycles++;
        end while (tick !== 1'b1 && cycles < limit);
    endtask

    task automatic expect_tick(input string tag, input int exp_n, input int exp_el);
        int c;
        count_to_tick(exp_n + 4, c);
        check({tag, "_period"}, c, exp_n);
        check({tag, "_elapsed"}, elapsed, exp_el);
`ifdef SNAKE_TICK_SQUARE_EN
        exp_sq = ~exp_sq;
        check({tag, "_sq"}, tick_sq, exp_sq);
`endif
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        pause = 1'b0;
        clear = 1'b0;
        level = 2'd0;
        lvl3  = 2'd0;
        lvl8  = 3'd0;
`ifdef SNAKE_TICK_SQUARE_EN
        exp_sq = 1'b0;
`endif
        repeat (2) step();
        check("rst_tick", tick, 0);
        check("rst_running", running, 0);
        check("rst_elapsed", elapsed, 0);
        reset = 1'b1;
        repeat (2) step();
        check("idle_running", running, 0);

        // Period arithmetic: clamp of out-of-range level, and the MIN_DIV floor.
        lvl3 = 2'd3; #1 check("calc3_clamp", p3, 6);
        lvl3 = 2'd1; #1 check("calc3_l1", p3, 8);
        lvl8 = 3'd7; #1 check("calc8_floor_l7", p8, 4);
        lvl8 = 3'd5; #1 check("calc8_floor_l5", p8, 4);
        lvl8 = 3'd2; #1 check("calc8_l2", p8, 6);
        lvl8 = 3'd0; #1 check("calc8_l0", p8, 10);

        // Start at level 0: running next cycle, ticks every 10.
        start = 1'b1;
        step();
        check("run_entry_running", running, 1);
        check("run_entry_tick", tick, 0);
        expect_tick("tick1", 10, 1);
        expect_tick("tick2", 10, 2);
        expect_tick("tick3", 10, 3);

        // Level 3 takes effect at the next boundary; a mid-period change does not.
        level = 2'd3;
        expect_tick("lvl3_pending", 10, 4);
        expect_tick("lvl3_fast", 4, 5);
        repeat (2) step();
        level = 2'd0;
        expect_tick("lvl_mid_change", 2, 6);
        expect_tick("lvl0_again", 10, 7);

        // Pause at counter=5 for 7 cycles: time frozen, then 5 more cycles.
        repeat (5) step();
        pause = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            check("pause_quiet", {tick, running}, 2'b00);
        end
        check("pause_elapsed", elapsed, 7);
        pause = 1'b0;
        expect_tick("pause_resume", 5, 8);

        // Pause coinciding with a wrap: tick still fires, then PAUSE.
        repeat (9) step();
        pause = 1'b1;
        step();
        check("pw_tick", tick, 1);
        check("pw_running", running, 0);
        check("pw_elapsed", elapsed, 9);
`ifdef SNAKE_TICK_SQUARE_EN
        exp_sq = ~exp_sq;
        check("pw_sq", tick_sq, exp_sq);
`endif
        pause = 1'b0;
        expect_tick("pw_resume", 11, 10);

        // Clear on the wrap cycle suppresses the tick and reloads the period from level 3.
        repeat (9) step();
        clear = 1'b1;
        level = 2'd3;
        step();
        clear = 1'b0;
        check("clr_tick", tick, 0);
        check("clr_elapsed", elapsed, 0);
        for (int i = 1; i <= 20; i++) begin
            expect_tick("sat", 4, (i > 15) ? 15 : i);
        end

        // Drop to IDLE: elapsed held, running low; restart latches level 0.
        start = 1'b0;
        level = 2'd0;
        step();
        check("idle_running2", running, 0);
        check("idle_elapsed_held", elapsed, 15);
`ifdef SNAKE_TICK_SQUARE_EN
        exp_sq = 1'b0;
        check("idle_sq", tick_sq, exp_sq);
`endif
        start = 1'b1;
        step();
        check("restart_running", running, 1);
        expect_tick("restart", 10, 15);

        // Asynchronous reset at counter=6.
        repeat (6) step();
        #2 reset = 1'b0;
        #1;
        check("arst_tick", tick, 0);
        check("arst_running", running, 0);
        check("arst_elapsed", elapsed, 0);
`ifdef SNAKE_TICK_SQUARE_EN
        exp_sq = 1'b0;
        check("arst_sq", tick_sq, exp_sq);
`endif
        reset = 1'b1;
        step();
        check("post_rst_running", running, 1);
        expect_tick("post_rst", 10, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
